// File: rtl/mul2_tour_pkg.sv
// Shared types and constants for the 2x2 multiplier tournament controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mul2_tour_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_SCORE,
        ST_UPDATE,
        ST_FINISH
    } state_t;

    // Lane i carries a = i[3:2], b = i[1:0]; together the 16 lanes cover every operand pair
    localparam logic [15:0] A1_VEC = 16'hFF00;
    localparam logic [15:0] A0_VEC = 16'hF0F0;
    localparam logic [15:0] B1_VEC = 16'hCCCC;
    localparam logic [15:0] B0_VEC = 16'hAAAA;

    // Correct product bits for the lanes above
    localparam logic [15:0] Y3_GOLD = 16'h8000;
    localparam logic [15:0] Y2_GOLD = 16'h4C00;
    localparam logic [15:0] Y1_GOLD = 16'h6AC0;
    localparam logic [15:0] Y0_GOLD = 16'hA0A0;

    localparam int SCORE_W = 7;
    localparam logic [SCORE_W-1:0] SCORE_NONE = 7'd127;

endpackage

// File: rtl/mul2_tournament_ctrl_popcount64.sv
// Counts set bits of a 64-bit error vector.
// Latency: combinational.
// Backpressure: none.
module popcount64 (
    input  logic [63:0] din,
    output logic [6:0]  cnt
);

    // Plain adder chain; synthesis balances it into a tree
    always_comb begin
        cnt = '0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(din[i]);
        end
    end

endmodule

// File: rtl/mul2_tournament_ctrl.sv
// Runs each candidate multiplier over all 16 operand pairs and reports the lowest-error one.
// Latency: start to done = N_CAND*(SETTLE_CYCLES+3)+1 cycles (fewer on early exit).
// Backpressure: none; start while busy is dropped. TOUR_SCORE_TRACE_EN adds per-candidate trace outputs.
module mul2_tournament_ctrl
    import mul2_tour_pkg::*;
#(
    parameter int N_CAND        = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int EARLY_EXIT    = 0,
    localparam int SEL_W        = (N_CAND > 1) ? $clog2(N_CAND) : 1,
    localparam int SET_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [SEL_W-1:0]   cand_sel,
    output logic [15:0]        cand_a1,
    output logic [15:0]        cand_a0,
    output logic [15:0]        cand_b1,
    output logic [15:0]        cand_b0,
    input  logic [15:0]        cand_y3,
    input  logic [15:0]        cand_y2,
    input  logic [15:0]        cand_y1,
    input  logic [15:0]        cand_y0,
`ifdef TOUR_SCORE_TRACE_EN
    output logic               trace_valid,
    output logic [SEL_W-1:0]   trace_idx,
    output logic [SCORE_W-1:0] trace_score,
`endif
    output logic [SEL_W-1:0]   winner_idx,
    output logic [SCORE_W-1:0] winner_score
);

    state_t               state;
    logic [SEL_W-1:0]     k;
    logic [SEL_W-1:0]     best_idx;
    logic [SCORE_W-1:0]   best_score;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   pc;
    logic [63:0]          err_vec;
    logic [SET_W-1:0]     settle;
    logic                 better;
    logic                 last;
    logic [SEL_W-1:0]     nb_idx;
    logic [SCORE_W-1:0]   nb_score;

    popcount64 u_pop (
        .din (err_vec),
        .cnt (pc)
    );

    // Strict less-than so ties keep the lower index; stop on last candidate or a perfect score when enabled
    always_comb begin
        better   = (score < best_score);
        nb_idx   = better ? k : best_idx;
        nb_score = better ? score : best_score;
        last     = (k == SEL_W'(N_CAND - 1)) || ((EARLY_EXIT != 0) && (score == '0));
    end

    // Tournament sequencer; all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            cand_sel     <= '0;
            cand_a1      <= '0;
            cand_a0      <= '0;
            cand_b1      <= '0;
            cand_b0      <= '0;
            winner_idx   <= '0;
            winner_score <= SCORE_NONE;
            k            <= '0;
            best_idx     <= '0;
            best_score   <= SCORE_NONE;
            score        <= '0;
            err_vec      <= '0;
            settle       <= '0;
`ifdef TOUR_SCORE_TRACE_EN
            trace_valid  <= 1'b0;
            trace_idx    <= '0;
            trace_score  <= '0;
`endif
        end else begin
`ifdef TOUR_SCORE_TRACE_EN
            trace_valid <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        busy       <= 1'b1;
                        k          <= '0;
                        best_idx   <= '0;
                        best_score <= SCORE_NONE;
                        cand_sel   <= '0;
                        cand_a1    <= A1_VEC;
                        cand_a0    <= A0_VEC;
                        cand_b1    <= B1_VEC;
                        cand_b0    <= B0_VEC;
                        settle     <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (settle == SET_W'(SETTLE_CYCLES - 1)) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle <= settle + SET_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    err_vec <= {cand_y3, cand_y2, cand_y1, cand_y0}
                             ^ {Y3_GOLD, Y2_GOLD, Y1_GOLD, Y0_GOLD};
                    cand_a1 <= '0;
                    cand_a0 <= '0;
                    cand_b1 <= '0;
                    cand_b0 <= '0;
                    state   <= ST_SCORE;
                end
                ST_SCORE: begin
                    score <= pc;
                    state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    best_idx   <= nb_idx;
                    best_score <= nb_score;
`ifdef TOUR_SCORE_TRACE_EN
                    trace_valid <= 1'b1;
                    trace_idx   <= k;
                    trace_score <= score;
`endif
                    if (last) begin
                        // Publish here so winner_* is valid in the same cycle done is high
                        winner_idx   <= nb_idx;
                        winner_score <= nb_score;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_FINISH;
                    end else begin
                        k        <= k + SEL_W'(1);
                        cand_sel <= k + SEL_W'(1);
                        cand_a1  <= A1_VEC;
                        cand_a0  <= A0_VEC;
                        cand_b1  <= B1_VEC;
                        cand_b0  <= B0_VEC;
                        settle   <= '0;
                        state    <= ST_DRIVE;
                    end
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul2_tournament_ctrl.sv
// Self-checking bench: behavioural contestants and a tournament model drive two controller instances.
// Latency: n/a.
// Backpressure: n/a.
module tb_mul2_tournament_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1;
    logic        busy0, busy1, done0, done1;
    logic [1:0]  sel0, sel1, widx0, widx1;
    logic [6:0]  wsc0, wsc1;
    logic [15:0] a1_0, a0_0, b1_0, b0_0, a1_1, a0_1, b1_1, b0_1;
    logic [63:0] yv0, yv1;
`ifdef TOUR_SCORE_TRACE_EN
    logic        tv0, tv1;
    logic [1:0]  ti0, ti1;
    logic [6:0]  ts0, ts1;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        ee = 1'b0;
    int          kind [4];
    logic [63:0] mask [4];
    logic [63:0] cresp [4];
    int          pw_idx [2];
    int          pw_sc [2];

    // Contestant lane model: exact 2x2 product per lane, optionally corrupted, or a fixed output
    function automatic logic [63:0] contestant(input logic [1:0] k, input logic [15:0] a1, a0, b1, b0);
        logic [63:0] r;
        logic [1:0]  a, b;
        logic [3:0]  p;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            a = {a1[i], a0[i]};
            b = {b1[i], b0[i]};
            p = a * b;
            r[48+i] = p[3];
            r[32+i] = p[2];
            r[16+i] = p[1];
            r[i]    = p[0];
        end
        if (kind[k] == 1) return cresp[k];
        return r ^ mask[k];
    endfunction

    function automatic logic [63:0] stim_vec();
        logic [63:0] s;
        logic [3:0]  li;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            li = 4'(i);
            s[48+i] = li[3];
            s[32+i] = li[2];
            s[16+i] = li[1];
            s[i]    = li[0];
        end
        return s;
    endfunction

    function automatic logic [63:0] gold_vec();
        logic [63:0] g;
        logic [3:0]  li, p;
        g = '0;
        for (int i = 0; i < 16; i++) begin
            li = 4'(i);
            p  = li[3:2] * li[1:0];
            g[48+i] = p[3];
            g[32+i] = p[2];
            g[16+i] = p[1];
            g[i]    = p[0];
        end
        return g;
    endfunction

    always_comb yv0 = contestant(sel0, a1_0, a0_0, b1_0, b0_0);
    always_comb yv1 = contestant(sel1, a1_1, a0_1, b1_1, b0_1);

    mul2_tournament_ctrl #(.N_CAND(4), .SETTLE_CYCLES(1), .EARLY_EXIT(0)) u_dut (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .cand_sel(sel0),
        .cand_a1(a1_0), .cand_a0(a0_0), .cand_b1(b1_0), .cand_b0(b0_0),
        .cand_y3(yv0[63:48]), .cand_y2(yv0[47:32]), .cand_y1(yv0[31:16]), .cand_y0(yv0[15:0]),
`ifdef TOUR_SCORE_TRACE_EN
        .trace_valid(tv0), .trace_idx(ti0), .trace_score(ts0),
`endif
        .winner_idx(widx0), .winner_score(wsc0)
    );

    mul2_tournament_ctrl #(.N_CAND(4), .SETTLE_CYCLES(1), .EARLY_EXIT(1)) u_dut_ee (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .cand_sel(sel1),
        .cand_a1(a1_1), .cand_a0(a0_1), .cand_b1(b1_1), .cand_b0(b0_1),
        .cand_y3(yv1[63:48]), .cand_y2(yv1[47:32]), .cand_y1(yv1[31:16]), .cand_y0(yv1[15:0]),
`ifdef TOUR_SCORE_TRACE_EN
        .trace_valid(tv1), .trace_idx(ti1), .trace_score(ts1),
`endif
        .winner_idx(widx1), .winner_score(wsc1)
    );

    logic        o_busy, o_done;
    logic [1:0]  o_sel, o_widx;
    logic [6:0]  o_wsc;
    logic [63:0] o_ops;
    assign o_busy = ee ? busy1 : busy0;
    assign o_done = ee ? done1 : done0;
    assign o_sel  = ee ? sel1 : sel0;
    assign o_widx = ee ? widx1 : widx0;
    assign o_wsc  = ee ? wsc1 : wsc0;
    assign o_ops  = ee ? {a1_1, a0_1, b1_1, b0_1} : {a1_0, a0_0, b1_0, b0_0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_cand(input int k, input int kd, input logic [63:0] v);
        kind[k] = kd;
        if (kd == 1) cresp[k] = v;
        else         mask[k]  = v;
    endtask

    // One tournament on the selected instance; reset_at > 0 asserts rst in that cycle after start
    task automatic run_tour(input bit use_ee, input int reset_at);
        int          exp_sc [4];
        int          n_eval, wi, ws, kk, pos, di;
        logic [63:0] s;
        ee = use_ee;
        di = use_ee ? 1 : 0;
        s  = stim_vec();
        n_eval = 0; ws = 127; wi = 0;
        for (int k = 0; k < 4; k++) begin
            exp_sc[k] = $countones(contestant(2'(k), s[63:48], s[47:32], s[31:16], s[15:0]) ^ gold_vec());
            n_eval = k + 1;
            if (exp_sc[k] < ws) begin ws = exp_sc[k]; wi = k; end
            if (use_ee && exp_sc[k] == 0) break;
        end
        @(negedge clk);
        start0 = !use_ee;
        start1 = use_ee;
        for (int cyc = 1; cyc <= 4 * n_eval + 3; cyc++) begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            if (reset_at > 0 && cyc == reset_at + 1) begin
                rst = 1'b0;
                check("rst_busy", o_busy, 0);
                check("rst_done", o_done, 0);
                check("rst_sel", o_sel, 0);
                check("rst_ops", o_ops, 0);
                check("rst_wsc", o_wsc, 127);
                for (int d = 0; d < 2; d++) begin pw_idx[d] = 0; pw_sc[d] = 127; end
                for (int j = 0; j < 20; j++) begin
                    @(negedge clk);
                    check("rst_no_done", o_done, 0);
                end
                return;
            end
            if (cyc <= 4 * n_eval) begin
                kk  = (cyc - 1) / 4;
                pos = (cyc - 1) % 4;
                check("run_busy", o_busy, 1);
                check("run_done", o_done, 0);
                check("run_sel", o_sel, kk);
                check("run_ops", o_ops, (pos < 2) ? s : 64'd0);
                check("hold_widx", o_widx, pw_idx[di]);
                check("hold_wsc", o_wsc, pw_sc[di]);
`ifdef TOUR_SCORE_TRACE_EN
                if (!use_ee) begin
                    check("trace_vld", tv0, (pos == 3) ? 1 : 0);
                    if (pos == 3) begin
                        check("trace_idx", ti0, kk);
                        check("trace_score", ts0, exp_sc[kk]);
                    end
                end
`endif
            end else if (cyc == 4 * n_eval + 1) begin
                check("fin_done", o_done, 1);
                check("fin_busy", o_busy, 0);
                check("fin_widx", o_widx, wi);
                check("fin_wsc", o_wsc, ws);
                pw_idx[di] = wi;
                pw_sc[di]  = ws;
            end else begin
                check("post_done", o_done, 0);
                check("post_busy", o_busy, 0);
                check("post_sel", o_sel, n_eval - 1);
                check("post_ops", o_ops, 0);
                check("post_widx", o_widx, pw_idx[di]);
                check("post_wsc", o_wsc, pw_sc[di]);
            end
            if (cyc == 5) begin
                start0 = !use_ee;
                start1 = use_ee;
            end
            if (reset_at > 0 && cyc == reset_at) rst = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        for (int d = 0; d < 2; d++) begin pw_idx[d] = 0; pw_sc[d] = 127; end
        for (int k = 0; k < 4; k++) begin kind[k] = 0; mask[k] = '0; cresp[k] = '0; end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            ee = d[0];
            #1;
            check("reset_busy", o_busy, 0);
            check("reset_done", o_done, 0);
            check("reset_sel", o_sel, 0);
            check("reset_ops", o_ops, 0);
            check("reset_widx", o_widx, 0);
            check("reset_wsc", o_wsc, 127);
        end
        rst = 1'b0;

        // Candidate 2 exact, others stuck at zero
        for (int k = 0; k < 4; k++) set_cand(k, 1, 64'd0);
        set_cand(2, 0, 64'd0);
        run_tour(0, 0);

        // Every output all ones: four-way tie
        for (int k = 0; k < 4; k++) set_cand(k, 1, {64{1'b1}});
        run_tour(0, 0);

        // Early exit on candidate 1
        for (int k = 0; k < 4; k++) set_cand(k, 1, 64'd0);
        set_cand(1, 0, 64'd0);
        run_tour(1, 0);

        // Reset during scoring of candidate 1, then a clean run
        run_tour(0, 7);
        run_tour(0, 0);

        // Randomized contestants
        for (int it = 0; it < 12; it++) begin
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: set_cand(k, 0, 64'd0);
                    1: set_cand(k, 0, 64'd1 << $urandom_range(0, 63));
                    2: set_cand(k, 0, {$urandom, $urandom});
                    default: set_cand(k, 1, {$urandom, $urandom});
                endcase
            end
            run_tour(bit'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
